// File: rtl/image_line_buffer_n.sv
// Multi-line image buffer: NUM_BUF line RAMs filled in round-robin order, read back as
// single lines or as sliding pairs of adjacent lines, with a 2-cycle read latency.
module image_line_buffer_n #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 11,
    parameter int NUM_BUF = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [ADDR_W-1:0] img_width,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              wr_ready,
    input  logic              rd_pair,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_finish,
    output logic              rd_ready,
    output logic              valid_o,
    output logic [DATA_W-1:0] data0_o,
    output logic [DATA_W-1:0] data1_o,
    output logic              overflow
);

    localparam int PTR_W = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
    localparam int CNT_W = $clog2(NUM_BUF + 1);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BUF - 1);
    localparam logic [CNT_W-1:0] ALL_FULL = CNT_W'(NUM_BUF);
    localparam logic [CNT_W-1:0] TWO_FULL = CNT_W'(2);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] wr_x_q, wr_x_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  full_cnt_q, full_cnt_d;
    logic              overflow_q, overflow_d;

    logic              s1_valid_q, s1_valid_d;
    logic [PTR_W-1:0]  s1_ptr0_q, s1_ptr0_d;
    logic [PTR_W-1:0]  s1_ptr1_q, s1_ptr1_d;
    logic              s1_pair_q, s1_pair_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;

    logic              wr_accept;
    logic              wr_line_done;
    logic              rd_release;
    logic [DATA_W-1:0] sel0;
    logic [DATA_W-1:0] sel1;
    logic [DATA_W-1:0] ram_rd [NUM_BUF];

    assign wr_ready     = (full_cnt_q < ALL_FULL);
    assign rd_ready     = rd_pair ? (full_cnt_q >= TWO_FULL) : (full_cnt_q != '0);
    assign wr_accept    = valid_i & wr_ready;
    assign wr_line_done = wr_accept & (wr_x_q == img_width - 1'b1);
    assign rd_release   = rd_finish & (full_cnt_q != '0);

    // Every buffer is read at rd_addr; the pipelined pointers choose among them afterwards.
    for (genvar g = 0; g < NUM_BUF; g++) begin : g_buf
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_data;

        always_ff @(posedge clk) begin
            if (wr_accept && !reset && (wr_ptr_q == PTR_W'(g))) begin
                mem[wr_x_q] <= data_i;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end

        assign ram_rd[g] = rd_data;
    end

    always_comb begin
        sel0 = '0;
        sel1 = '0;
        for (int unsigned b = 0; b < NUM_BUF; b++) begin
            if (s1_ptr0_q == PTR_W'(b)) begin
                sel0 = ram_rd[b];
            end
            if (s1_ptr1_q == PTR_W'(b)) begin
                sel1 = ram_rd[b];
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_x_d      = wr_x_q;
        rd_ptr_d    = rd_ptr_q;
        full_cnt_d  = full_cnt_q;
        overflow_d  = overflow_q;
        s1_valid_d  = rd_en;
        s1_ptr0_d   = rd_ptr_q;
        s1_ptr1_d   = ptr_inc(rd_ptr_q);
        s1_pair_d   = rd_pair;
        out_valid_d = s1_valid_q;
        data0_d     = data0_q;
        data1_d     = data1_q;

        if (wr_accept) begin
            wr_x_d = wr_line_done ? '0 : wr_x_q + 1'b1;
        end
        if (wr_line_done) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (valid_i && !wr_ready) begin
            overflow_d = 1'b1;
        end
        if (rd_release) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({wr_line_done, rd_release})
            2'b10:   full_cnt_d = full_cnt_q + 1'b1;
            2'b01:   full_cnt_d = full_cnt_q - 1'b1;
            default: full_cnt_d = full_cnt_q;
        endcase

        // Line selection travels with the request, so a concurrent rd_finish cannot retarget it.
        if (s1_valid_q) begin
            data0_d = sel0;
            data1_d = s1_pair_q ? sel1 : sel0;
        end

        if (flush) begin
            wr_ptr_d    = '0;
            wr_x_d      = '0;
            rd_ptr_d    = '0;
            full_cnt_d  = '0;
            overflow_d  = 1'b0;
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            wr_x_q      <= '0;
            rd_ptr_q    <= '0;
            full_cnt_q  <= '0;
            overflow_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_ptr0_q   <= '0;
            s1_ptr1_q   <= '0;
            s1_pair_q   <= 1'b0;
            out_valid_q <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_x_q      <= wr_x_d;
            rd_ptr_q    <= rd_ptr_d;
            full_cnt_q  <= full_cnt_d;
            overflow_q  <= overflow_d;
            s1_valid_q  <= s1_valid_d;
            s1_ptr0_q   <= s1_ptr0_d;
            s1_ptr1_q   <= s1_ptr1_d;
            s1_pair_q   <= s1_pair_d;
            out_valid_q <= out_valid_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
        end
    end

    assign valid_o  = out_valid_q;
    assign data0_o  = data0_q;
    assign data1_o  = data1_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_image_line_buffer_n.sv
// Directed bench for image_line_buffer_n: a 4-buffer instance and a 3-buffer instance,
// with read results checked against scoreboard queues filled when each read is issued.
module tb_image_line_buffer_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: NUM_BUF=4
    logic        a_rst = 1'b1, a_flush = 1'b0, a_vi = 1'b0, a_rd_pair = 1'b0;
    logic        a_rd_en = 1'b0, a_rd_fin = 1'b0;
    logic [10:0] a_img_w = 11'd8, a_rd_addr = '0;
    logic [23:0] a_di = '0;
    logic        a_wr_ready, a_rd_ready, a_vo, a_ovf;
    logic [23:0] a_d0, a_d1;

    // Instance B: NUM_BUF=3
    logic        b_rst = 1'b1, b_flush = 1'b0, b_vi = 1'b0, b_rd_pair = 1'b0;
    logic        b_rd_en = 1'b0, b_rd_fin = 1'b0;
    logic [10:0] b_img_w = 11'd4, b_rd_addr = '0;
    logic [23:0] b_di = '0;
    logic        b_wr_ready, b_rd_ready, b_vo, b_ovf;
    logic [23:0] b_d0, b_d1;

    logic [47:0] qa[$];
    logic [47:0] qb[$];

    image_line_buffer_n #(.DATA_W(24), .ADDR_W(11), .NUM_BUF(4)) dut_a (
        .clk(clk), .reset(a_rst), .flush(a_flush), .img_width(a_img_w),
        .valid_i(a_vi), .data_i(a_di), .wr_ready(a_wr_ready), .rd_pair(a_rd_pair),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_finish(a_rd_fin), .rd_ready(a_rd_ready),
        .valid_o(a_vo), .data0_o(a_d0), .data1_o(a_d1), .overflow(a_ovf)
    );

    image_line_buffer_n #(.DATA_W(24), .ADDR_W(11), .NUM_BUF(3)) dut_b (
        .clk(clk), .reset(b_rst), .flush(b_flush), .img_width(b_img_w),
        .valid_i(b_vi), .data_i(b_di), .wr_ready(b_wr_ready), .rd_pair(b_rd_pair),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_finish(b_rd_fin), .rd_ready(b_rd_ready),
        .valid_o(b_vo), .data0_o(b_d0), .data1_o(b_d1), .overflow(b_ovf)
    );

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_a
        logic [47:0] e;
        if (a_vo === 1'b1) begin
            chk("a_sb_has_entry", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_read_data", {a_d0, a_d1}, e);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [47:0] e;
        if (b_vo === 1'b1) begin
            chk("b_sb_has_entry", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_read_data", {b_d0, b_d1}, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1);
    end

    task automatic wr_a(input logic [23:0] d);
        a_vi = 1'b1;
        a_di = d;
        tick();
        a_vi = 1'b0;
    endtask

    task automatic fin_a();
        a_rd_fin = 1'b1;
        tick();
        a_rd_fin = 1'b0;
    endtask

    task automatic rd_a(input logic [10:0] addr, input logic pair,
                        input logic [23:0] e0, input logic [23:0] e1, input logic fin);
        a_rd_pair = pair;
        a_rd_addr = addr;
        a_rd_en   = 1'b1;
        a_rd_fin  = fin;
        qa.push_back({e0, e1});
        tick();
        a_rd_en  = 1'b0;
        a_rd_fin = 1'b0;
        chk("a_latency_n1", a_vo, 0);
        tick();
        chk("a_latency_n2", a_vo, 1);
        @(negedge clk);
        #1;
        chk("a_sb_drained", qa.size(), 0);
        tick();
    endtask

    task automatic wr_line_b(input int k);
        for (int c = 0; c < 4; c++) begin
            b_vi = 1'b1;
            b_di = 24'(16 * k + c);
            tick();
        end
        b_vi = 1'b0;
    endtask

    task automatic fin_b();
        b_rd_fin = 1'b1;
        tick();
        b_rd_fin = 1'b0;
    endtask

    task automatic rd_b(input logic [10:0] addr, input logic pair,
                        input logic [23:0] e0, input logic [23:0] e1);
        b_rd_pair = pair;
        b_rd_addr = addr;
        b_rd_en   = 1'b1;
        qb.push_back({e0, e1});
        tick();
        b_rd_en = 1'b0;
        tick();
        chk("b_latency_n2", b_vo, 1);
        @(negedge clk);
        #1;
        chk("b_sb_drained", qb.size(), 0);
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("a_reset_valid_o", a_vo, 0);
        chk("a_reset_data0", a_d0, 0);
        chk("a_reset_data1", a_d1, 0);
        chk("a_reset_overflow", a_ovf, 0);
        chk("a_reset_wr_ready", a_wr_ready, 1);
        chk("a_reset_rd_ready", a_rd_ready, 0);
        a_rst = 1'b0;
        tick();

        // Fill all four lines with 16*line+col
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 8; c++) begin
                if (l == 3 && c == 7) chk("a_wr_ready_before_32nd", a_wr_ready, 1);
                wr_a(24'(16 * l + c));
            end
            if (l == 0) chk("a_rd_ready_one_line", a_rd_ready, 1);
        end
        chk("a_wr_ready_full", a_wr_ready, 0);
        rd_a(11'd3, 1'b0, 24'h03, 24'h03, 1'b0);

        wr_a(24'hBADBAD);
        chk("a_overflow_set", a_ovf, 1);
        chk("a_wr_ready_still_full", a_wr_ready, 0);
        chk("a_rd_ready_after_drop", a_rd_ready, 1);

        rd_a(11'd5, 1'b1, 24'h05, 24'h15, 1'b0);
        fin_a();
        chk("a_wr_ready_after_finish", a_wr_ready, 1);
        rd_a(11'd5, 1'b1, 24'h15, 24'h25, 1'b0);

        // Line 4 completes in the same cycle as a release at full_cnt=2
        fin_a();
        for (int c = 0; c < 7; c++) wr_a(24'(8'h40 + c));
        a_vi     = 1'b1;
        a_di     = 24'h47;
        a_rd_fin = 1'b1;
        tick();
        a_vi     = 1'b0;
        a_rd_fin = 1'b0;
        a_rd_pair = 1'b1;
        #1;
        chk("a_same_cycle_rd_ready_pair", a_rd_ready, 1);
        chk("a_same_cycle_wr_ready", a_wr_ready, 1);
        rd_a(11'd2, 1'b1, 24'h32, 24'h42, 1'b0);
        fin_a();
        a_rd_pair = 1'b1;
        #1;
        chk("a_one_line_pair_not_ready", a_rd_ready, 0);
        a_rd_pair = 1'b0;
        #1;
        chk("a_one_line_single_ready", a_rd_ready, 1);
        fin_a();
        chk("a_empty_rd_ready", a_rd_ready, 0);
        chk("a_overflow_sticky", a_ovf, 1);
        fin_a();
        for (int c = 0; c < 8; c++) wr_a(24'(8'h50 + c));
        rd_a(11'd6, 1'b0, 24'h56, 24'h56, 1'b1);
        chk("a_empty_after_read_finish", a_rd_ready, 0);

        a_img_w = 11'd1;
        wr_a(24'h77);
        chk("a_width1_rd_ready", a_rd_ready, 1);
        wr_a(24'h78);
        a_rd_pair = 1'b1;
        #1;
        chk("a_width1_pair_ready", a_rd_ready, 1);
        rd_a(11'd0, 1'b1, 24'h77, 24'h78, 1'b0);

        // Flush mid-line with a read in flight
        a_img_w   = 11'd8;
        a_rd_pair = 1'b0;
        for (int c = 0; c < 4; c++) wr_a(24'(8'h80 + c));
        a_rd_addr = 11'd1;
        a_rd_en   = 1'b1;
        tick();
        a_rd_en = 1'b0;
        a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        chk("a_flush_wr_ready", a_wr_ready, 1);
        chk("a_flush_rd_ready", a_rd_ready, 0);
        chk("a_flush_overflow", a_ovf, 0);
        chk("a_flush_valid_o", a_vo, 0);
        tick();
        tick();
        for (int c = 0; c < 8; c++) wr_a(24'(8'h90 + c));
        rd_a(11'd0, 1'b0, 24'h90, 24'h90, 1'b0);

        // Reset with a read in flight
        a_rd_addr = 11'd1;
        a_rd_en   = 1'b1;
        tick();
        a_rd_en = 1'b0;
        a_rst   = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("a_rst_mid_valid_o", a_vo, 0);
        chk("a_rst_mid_data0", a_d0, 0);
        chk("a_rst_mid_wr_ready", a_wr_ready, 1);
        chk("a_rst_mid_rd_ready", a_rd_ready, 0);
        chk("a_rst_mid_overflow", a_ovf, 0);
        tick();
        tick();
        chk("a_rst_no_late_valid", a_vo, 0);

        // Instance B: 7 lines through 3 buffers as a sliding pair window
        b_rst = 1'b0;
        tick();
        chk("b_reset_wr_ready", b_wr_ready, 1);
        chk("b_reset_rd_ready", b_rd_ready, 0);
        wr_line_b(0);
        wr_line_b(1);
        for (int k = 0; k < 6; k++) begin
            rd_b(11'(k % 4), 1'b1, 24'(16 * k + k % 4), 24'(16 * (k + 1) + k % 4));
            fin_b();
            if (k + 2 <= 6) wr_line_b(k + 2);
        end
        rd_b(11'd1, 1'b0, 24'h61, 24'h61);
        chk("b_final_overflow", b_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/image_line_buffer_n.md
IMAGE_LINE_BUFFER_N -- requirements
Module: image_line_buffer_n

Interface
REQ-001 Parameter DATA_W, default 24, pixel width in bits.
REQ-002 Parameter ADDR_W, default 11, line address width; maximum line length is 2^ADDR_W pixels.
REQ-003 Parameter NUM_BUF, default 4, number of line buffers; legal range 2..8, need not be a power of two.
REQ-004 clk  in  1  single clock for all logic; the block has one clock, and reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous clear of all pointers and counters, for start of frame.
REQ-007 img_width  in  ADDR_W  pixels per line; sampled each cycle and held stable within a frame.
REQ-008 valid_i  in  1  write strobe for data_i.
REQ-009 data_i  in  DATA_W  input pixel.
REQ-010 wr_ready  out  1  at least one line buffer is free.
REQ-011 rd_pair  in  1  0 = single-line read, 1 = two-adjacent-line read; changed only while rd_en=0.
REQ-012 rd_en  in  1  read request for rd_addr.
REQ-013 rd_addr  in  ADDR_W  pixel column to read.
REQ-014 rd_finish  in  1  one-cycle pulse; releases the oldest full line.
REQ-015 rd_ready  out  1  enough full lines are available for the current rd_pair mode.
REQ-016 valid_o  out  1  output data valid.
REQ-017 data0_o  out  DATA_W  pixel from the oldest full line.
REQ-018 data1_o  out  DATA_W  pixel from the next line (rd_pair=1); otherwise equal to data0_o.
REQ-019 overflow  out  1  sticky flag: a write was attempted while wr_ready=0.

Function
REQ-020 Storage SHALL be NUM_BUF inferred simple-dual-port RAMs of 2^ADDR_W x DATA_W with a 1-cycle read.
REQ-021 Write side: wr_ptr (0..NUM_BUF-1) selects the buffer and wr_x (0..img_width-1) is the address.
- Each accepted valid_i writes data_i and increments wr_x.
REQ-022 Line completion: an accepted write with wr_x==img_width-1 SHALL set wr_x=0 and advance wr_ptr with modulo-NUM_BUF wrap.
- This event is wr_line_done.
REQ-023 A write is accepted only when valid_i=1 and wr_ready=1.
- When valid_i=1 and wr_ready=0, the data SHALL be dropped, pointers held, and overflow set until reset or flush.
REQ-024 full_cnt (0..NUM_BUF) SHALL track full lines:
- +1 on wr_line_done;
- -1 on an accepted rd_finish;
- unchanged when both occur in the same cycle.
REQ-025 wr_ready SHALL be 1 when full_cnt < NUM_BUF, combinationally from registered state.
REQ-026 rd_ready SHALL be 1 when full_cnt >= 1 (rd_pair=0) or full_cnt >= 2 (rd_pair=1).
REQ-027 rd_ptr SHALL select the oldest full line.
- An accepted rd_finish advances rd_ptr by one with modulo wrap in both modes.
- In pair mode, line rd_ptr+1 therefore becomes the next oldest: a sliding window.
REQ-028 An rd_finish with full_cnt==0 SHALL be ignored: no pointer or count change.
REQ-029 Read latency SHALL be exactly 2 cycles: rd_en/rd_addr at cycle N produce valid_o=1 and data at cycle N+2.
- The buffer selection is the rd_ptr value at cycle N, pipelined alongside the request.
REQ-030 data0_o SHALL come from buffer rd_ptr and data1_o from buffer (rd_ptr+1) mod NUM_BUF.
- When rd_pair=0, data1_o SHALL equal data0_o.
REQ-031 rd_finish in the same cycle as rd_en SHALL NOT alter the line selection of that read or of reads already in flight.
REQ-032 Reading a line that is being written, or reading with rd_ready=0, is a user error; the output data is then don't-care, but valid_o still follows rd_en.
REQ-033 flush SHALL clear wr_ptr, wr_x, rd_ptr, full_cnt, overflow and the valid pipeline in one cycle.
- RAM contents are retained.
- If flush and reset are both asserted, reset has priority.
REQ-034 img_width=0 is unsupported; img_width=1 SHALL complete a line on every accepted write.

Reset
REQ-035 On reset SHALL hold: valid_o=0, data0_o=0, data1_o=0, overflow=0, wr_ptr=0, wr_x=0, rd_ptr=0, full_cnt=0.
- Consequently wr_ready=1 and rd_ready=0.
REQ-036 Reset asserted mid-line or mid-read SHALL discard all partial lines and in-flight reads; the cycle after release behaves as after power-up.

Verification
REQ-037 NUM_BUF=4, img_width=8: write 4 lines of value 16*line+col -> wr_ready=0 after the 32nd write.
- A read of rd_addr=3 then returns data0_o=0x03 two cycles later.
REQ-038 With the buffer full, drive 1 extra valid_i -> overflow=1, the data is dropped, and full_cnt stays 4.
REQ-039 rd_pair=1, lines 0..1 full, read rd_addr=5 -> data0_o=0x05 and data1_o=0x15.
- After rd_finish, the next read gives 0x15/0x25 once line 2 is full.
REQ-040 wr_line_done and rd_finish in the same cycle with full_cnt=2 -> full_cnt stays 2, and wr_ptr and rd_ptr both advance.
REQ-041 Pointer wrap with NUM_BUF=3: 7 lines written and released alternately -> reads return line data 0..6 in order with no repeats.
REQ-042 flush mid-line (wr_x=4) and reset mid-read -> wr_ready=1, rd_ready=0, overflow=0 the next cycle, and no valid_o from in-flight reads.
